decode_stage: RTL
=================

Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS pipeline, between the fetch stage (IF/ID register) and the execute stage.
- Decodes a MIPS subset and drives the register-file read addresses.
- Registers the ID/EXE operand/control fields.
- Enforces RAW interlocks with an internal 3-deep destination scoreboard (no forwarding), and handles jump flush and memory-stall freeze.

Parameters:
PC_W, 30, word-address PC width
SB_DEPTH, 3, scoreboard depth (EXE, MEM, WB in flight)

Ports:
clk  in  1  clock
reset  in  1  reset
if_valid  in  1  IF/ID holds a valid instruction
if_pc  in  PC_W  word PC of IF/ID instruction
if_ins  in  32  IF/ID instruction
id_stall  out  1  fetch must hold PC and IF/ID (combinational)
rs_addr  out  5  register-file read address 0 = ins[25:21]
rt_addr  out  5  register-file read address 1 = ins[20:16]
rs_data  in  32  register-file read data 0
rt_data  in  32  register-file read data 1
exe_flush  in  1  EXE resolved a taken branch/jump this cycle
mem_stall  in  1  MEM awaiting RAM response; freeze whole pipeline
ex_valid  out  1  ID/EXE entry valid
ex_pc  out  PC_W  PC of entry
ex_aluop  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 PASSB
ex_a  out  32  operand A (rs_data)
ex_b  out  32  operand B (rt_data or immediate)
ex_st_data  out  32  store data (rt_data)
ex_imm  out  32  extended immediate / jump index
ex_dest  out  5  destination register
ex_reg_we  out  1  writes register file
ex_mem_rd  out  1  LW
ex_mem_wr  out  1  SW
ex_br  out  2  0 none, 1 BEQ, 2 BNE, 3 J
ex_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset is synchronous and active-high. At reset every ex_* output is 0 and all scoreboard entries are invalid. id_stall is 0 during reset.
- Decode:
  - R-type (op 0): funct 21 ADDU, 23 SUBU, 24 AND, 25 OR, 26 XOR, 2A SLT. dest=rd, reads rs and rt, b=rt_data.
  - ADDIU 09: sign-extended imm.
  - ANDI 0C / ORI 0D: zero-extended imm.
  - LUI 0F: imm={ins[15:0],16'h0}, PASSB.
  - For ADDIU, ANDI, ORI, LUI: dest=rt, b=imm.
  - LW 23: ADD, sign-extended imm, dest=rt, mem_rd.
  - SW 2B: ADD, sign-extended imm, mem_wr, reads rs and rt, reg_we=0.
  - BEQ 04 / BNE 05: SUB, a=rs, b=rt, sign-extended imm, reg_we=0.
  - J 02: imm={6'h0,ins[25:0]}, reg_we=0, reads nothing.
  - Any other op or funct: ex_illegal=1, reg_we, mem_rd and mem_wr all 0, aluop ADD.
- ex_reg_we is forced to 0 when dest==0.
- Source-usage flags:
  - use_rs for R-type, ADDIU, ANDI, ORI, LW, SW, BEQ, BNE.
  - use_rt for R-type, SW, BEQ, BNE.
- Scoreboard holds 3 entries {valid, dest}, index 0=EXE, 1=MEM, 2=WB.
  - An entry is valid only when the instruction has reg_we=1.
- hazard = if_valid & ((use_rs & rs!=0 & rs matches any valid entry) | (use_rt & rt!=0 & rt matches any valid entry)).
- id_stall = mem_stall | (hazard & ~exe_flush).
- Per-cycle priority, evaluated each rising edge:
  1. reset: clear everything.
  2. mem_stall=1: hold all ex_* outputs and the scoreboard unchanged. This applies even if exe_flush is also 1; EXE must re-assert exe_flush after the stall.
  3. exe_flush=1: ex_valid<=0 (all ex_* control bits cleared). The scoreboard shifts with a bubble in entry 0. The current IF/ID instruction is discarded.
  4. hazard=1: insert a bubble (ex_valid<=0, control bits 0). The scoreboard shifts with a bubble. IF/ID is held by id_stall.
  5. if_valid=0: bubble, scoreboard shifts.
  6. Otherwise: register the decoded instruction with ex_valid<=1, push {reg_we,dest} into entry 0, shift 0->1->2, drop entry 2.
- Latency: 1 cycle from IF/ID to ID/EXE.
- Back-to-back dependent instructions incur exactly 3 bubble cycles, because the WB write lands at the end of its WB cycle.
- rs_addr and rt_addr are combinational from if_ins, independent of stall.

Test Plan:
- Reset mid-stream: assert reset for 1 cycle while ex_valid=1 and the scoreboard is full -> next cycle all ex_*=0 and id_stall=0. An independent instruction issues on the first post-reset cycle.
- ADDIU $1,$0,-1 (0x2401FFFF), if_pc=5 -> next cycle ex_valid=1, ex_pc=5, ex_aluop=0, ex_b=0xFFFFFFFF, ex_dest=1, ex_reg_we=1. LUI $2,0x1234 -> ex_b=0x12340000, ex_aluop=6.
- RAW interlock: ADDU $3,$1,$2 then SUBU $4,$3,$3 -> id_stall=1 for 3 cycles with 3 bubbles, then SUBU issues. Writes to $0 (ADDU $0,$1,$2) followed by a reader of $0 -> no stall.
- Flush: exe_flush=1 while IF/ID holds a valid ADDU -> next cycle ex_valid=0, no scoreboard entry for it. Flush coincident with a hazard -> id_stall=0.
- mem_stall held 4 cycles with LW $5,8($6) in ID/EXE -> ex_* unchanged for 4 cycles, id_stall=1. A dependent instruction still gets 3 bubbles after release.
- Illegal opcode 0x3F / R-type funct 0x3F -> ex_valid=1, ex_illegal=1, ex_reg_we=0, ex_mem_wr=0, scoreboard entry invalid.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: ID stage of a 5-stage MIPS pipeline.
// Decodes a MIPS subset and drives the register-file read ports.
// Registers the ID/EXE fields.
// Interlocks RAW hazards against a small scoreboard of in-flight destinations.
// There is no forwarding.
//
// Stall/valid contract with the neighbouring stages:
//   - if_valid says IF/ID holds an instruction.
//   - While id_stall is 1, fetch must hold its PC and IF/ID unchanged.
//   - The instruction in IF/ID is consumed on a rising edge only when all of
//     the following are true: id_stall=0, exe_flush=0 and if_valid=1.
//   - ex_valid qualifies every ex_* field.
//   - Every ex_* field is all zero when ex_valid is 0.
//   - While mem_stall is 1, ID/EXE and the scoreboard hold their values.
module decode_stage #(
  parameter int PC_W     = 30,
  parameter int SB_DEPTH = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  input  logic [31:0]     if_ins,
  output logic            id_stall,
  output logic [4:0]      rs_addr,
  output logic [4:0]      rt_addr,
  input  logic [31:0]     rs_data,
  input  logic [31:0]     rt_data,
  input  logic            exe_flush,
  input  logic            mem_stall,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [3:0]      ex_aluop,
  output logic [31:0]     ex_a,
  output logic [31:0]     ex_b,
  output logic [31:0]     ex_st_data,
  output logic [31:0]     ex_imm,
  output logic [4:0]      ex_dest,
  output logic            ex_reg_we,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic [1:0]      ex_br,
  output logic            ex_illegal
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_PASSB = 4'd6;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_J    = 2'd3;

  // Instruction fields
  logic [5:0]  op_f;
  logic [5:0]  funct_f;
  logic [4:0]  rs_f;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [31:0] imm_sx;
  logic [31:0] imm_zx;
  logic [31:0] imm_lui;
  logic [31:0] imm_j;

  assign op_f    = if_ins[31:26];
  assign rs_f    = if_ins[25:21];
  assign rt_f    = if_ins[20:16];
  assign rd_f    = if_ins[15:11];
  assign funct_f = if_ins[5:0];
  assign imm_sx  = {{16{if_ins[15]}}, if_ins[15:0]};
  assign imm_zx  = {16'h0, if_ins[15:0]};
  assign imm_lui = {if_ins[15:0], 16'h0};
  assign imm_j   = {6'h0, if_ins[25:0]};

  assign rs_addr = rs_f;
  assign rt_addr = rt_f;

  // Decoded controls
  logic [3:0]  dec_aluop;
  logic [31:0] dec_imm;
  logic        dec_b_imm;
  logic [4:0]  dec_dest;
  logic        dec_we_raw;
  logic        dec_we;
  logic        dec_mem_rd;
  logic        dec_mem_wr;
  logic [1:0]  dec_br;
  logic        dec_ill;
  logic        use_rs;
  logic        use_rt;

  // Combinational decode of the IF/ID instruction
  always_comb begin
    dec_aluop  = ALU_ADD;
    dec_imm    = 32'h0;
    dec_b_imm  = 1'b0;
    dec_dest   = 5'd0;
    dec_we_raw = 1'b0;
    dec_mem_rd = 1'b0;
    dec_mem_wr = 1'b0;
    dec_br     = BR_NONE;
    dec_ill    = 1'b0;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    case (op_f)
      6'h00: begin
        use_rs     = 1'b1;
        use_rt     = 1'b1;
        dec_dest   = rd_f;
        dec_we_raw = 1'b1;
        case (funct_f)
          6'h21:   dec_aluop = ALU_ADD;
          6'h23:   dec_aluop = ALU_SUB;
          6'h24:   dec_aluop = ALU_AND;
          6'h25:   dec_aluop = ALU_OR;
          6'h26:   dec_aluop = ALU_XOR;
          6'h2A:   dec_aluop = ALU_SLT;
          default: begin
            dec_ill    = 1'b1;
            dec_we_raw = 1'b0;
            dec_dest   = 5'd0;
          end
        endcase
      end
      6'h09: begin
        use_rs     = 1'b1;
        dec_imm    = imm_sx;
        dec_b_imm  = 1'b1;
        dec_dest   = rt_f;
        dec_we_raw = 1'b1;
      end
      6'h0C: begin
        use_rs     = 1'b1;
        dec_aluop  = ALU_AND;
        dec_imm    = imm_zx;
        dec_b_imm  = 1'b1;
        dec_dest   = rt_f;
        dec_we_raw = 1'b1;
      end
      6'h0D: begin
        use_rs     = 1'b1;
        dec_aluop  = ALU_OR;
        dec_imm    = imm_zx;
        dec_b_imm  = 1'b1;
        dec_dest   = rt_f;
        dec_we_raw = 1'b1;
      end
      6'h0F: begin
        dec_aluop  = ALU_PASSB;
        dec_imm    = imm_lui;
        dec_b_imm  = 1'b1;
        dec_dest   = rt_f;
        dec_we_raw = 1'b1;
      end
      6'h23: begin
        use_rs     = 1'b1;
        dec_imm    = imm_sx;
        dec_b_imm  = 1'b1;
        dec_dest   = rt_f;
        dec_we_raw = 1'b1;
        dec_mem_rd = 1'b1;
      end
      6'h2B: begin
        use_rs     = 1'b1;
        use_rt     = 1'b1;
        dec_imm    = imm_sx;
        dec_b_imm  = 1'b1;
        dec_mem_wr = 1'b1;
      end
      6'h04, 6'h05: begin
        use_rs    = 1'b1;
        use_rt    = 1'b1;
        dec_aluop = ALU_SUB;
        dec_imm   = imm_sx;
        dec_br    = (op_f == 6'h04) ? BR_BEQ : BR_BNE;
      end
      6'h02: begin
        dec_imm   = imm_j;
        dec_b_imm = 1'b1;
        dec_br    = BR_J;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // $0 is hard-wired, so a write to it is dropped.
  // Because the write is dropped, it never occupies a scoreboard entry.
  assign dec_we = dec_we_raw & (dec_dest != 5'd0);

  // Scoreboard: entry 0 = EXE, 1 = MEM, 2 = WB
  logic [SB_DEPTH-1:0]      sb_valid_q, sb_valid_d;
  logic [SB_DEPTH-1:0][4:0] sb_dest_q, sb_dest_d;
  logic                     rs_hit;
  logic                     rt_hit;
  logic                     hazard;
  logic                     issue;

  // RAW check of the IF/ID sources against every in-flight destination
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (sb_valid_q[k] && (sb_dest_q[k] == rs_f)) rs_hit = 1'b1;
      if (sb_valid_q[k] && (sb_dest_q[k] == rt_f)) rt_hit = 1'b1;
    end
    hazard = if_valid & ((use_rs & (rs_f != 5'd0) & rs_hit) |
                         (use_rt & (rt_f != 5'd0) & rt_hit));
  end

  // A flush wins over a hazard.
  // The stalled instruction is being discarded anyway, so fetch must not hold it.
  assign id_stall = ~reset & (mem_stall | (hazard & ~exe_flush));
  assign issue    = if_valid & ~exe_flush & ~hazard;

  // ID/EXE register state
  logic            ex_valid_q, ex_valid_d;
  logic [PC_W-1:0] ex_pc_q, ex_pc_d;
  logic [3:0]      ex_aluop_q, ex_aluop_d;
  logic [31:0]     ex_a_q, ex_a_d;
  logic [31:0]     ex_b_q, ex_b_d;
  logic [31:0]     ex_st_q, ex_st_d;
  logic [31:0]     ex_imm_q, ex_imm_d;
  logic [4:0]      ex_dest_q, ex_dest_d;
  logic            ex_we_q, ex_we_d;
  logic            ex_rd_q, ex_rd_d;
  logic            ex_wr_q, ex_wr_d;
  logic [1:0]      ex_br_q, ex_br_d;
  logic            ex_ill_q, ex_ill_d;

  // Next state: hold on mem_stall, otherwise issue or bubble and shift the scoreboard
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_aluop_d = ex_aluop_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_st_d    = ex_st_q;
    ex_imm_d   = ex_imm_q;
    ex_dest_d  = ex_dest_q;
    ex_we_d    = ex_we_q;
    ex_rd_d    = ex_rd_q;
    ex_wr_d    = ex_wr_q;
    ex_br_d    = ex_br_q;
    ex_ill_d   = ex_ill_q;
    sb_valid_d = sb_valid_q;
    sb_dest_d  = sb_dest_q;
    if (!mem_stall) begin
      sb_valid_d = {sb_valid_q[SB_DEPTH-2:0], issue & dec_we};
      sb_dest_d  = {sb_dest_q[SB_DEPTH-2:0], (issue & dec_we) ? dec_dest : 5'd0};
      ex_valid_d = 1'b0;
      ex_pc_d    = '0;
      ex_aluop_d = 4'd0;
      ex_a_d     = 32'h0;
      ex_b_d     = 32'h0;
      ex_st_d    = 32'h0;
      ex_imm_d   = 32'h0;
      ex_dest_d  = 5'd0;
      ex_we_d    = 1'b0;
      ex_rd_d    = 1'b0;
      ex_wr_d    = 1'b0;
      ex_br_d    = 2'd0;
      ex_ill_d   = 1'b0;
      if (issue) begin
        ex_valid_d = 1'b1;
        ex_pc_d    = if_pc;
        ex_aluop_d = dec_aluop;
        ex_a_d     = rs_data;
        ex_b_d     = dec_b_imm ? dec_imm : rt_data;
        ex_st_d    = rt_data;
        ex_imm_d   = dec_imm;
        ex_dest_d  = dec_dest;
        ex_we_d    = dec_we;
        ex_rd_d    = dec_mem_rd;
        ex_wr_d    = dec_mem_wr;
        ex_br_d    = dec_br;
        ex_ill_d   = dec_ill;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_aluop_q <= 4'd0;
      ex_a_q     <= 32'h0;
      ex_b_q     <= 32'h0;
      ex_st_q    <= 32'h0;
      ex_imm_q   <= 32'h0;
      ex_dest_q  <= 5'd0;
      ex_we_q    <= 1'b0;
      ex_rd_q    <= 1'b0;
      ex_wr_q    <= 1'b0;
      ex_br_q    <= 2'd0;
      ex_ill_q   <= 1'b0;
      sb_valid_q <= '0;
      sb_dest_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_aluop_q <= ex_aluop_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_st_q    <= ex_st_d;
      ex_imm_q   <= ex_imm_d;
      ex_dest_q  <= ex_dest_d;
      ex_we_q    <= ex_we_d;
      ex_rd_q    <= ex_rd_d;
      ex_wr_q    <= ex_wr_d;
      ex_br_q    <= ex_br_d;
      ex_ill_q   <= ex_ill_d;
      sb_valid_q <= sb_valid_d;
      sb_dest_q  <= sb_dest_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_aluop   = ex_aluop_q;
  assign ex_a       = ex_a_q;
  assign ex_b       = ex_b_q;
  assign ex_st_data = ex_st_q;
  assign ex_imm     = ex_imm_q;
  assign ex_dest    = ex_dest_q;
  assign ex_reg_we  = ex_we_q;
  assign ex_mem_rd  = ex_rd_q;
  assign ex_mem_wr  = ex_wr_q;
  assign ex_br      = ex_br_q;
  assign ex_illegal = ex_ill_q;

endmodule
